// File: rtl/lc4_wb_arbiter_if.sv
// Writeback arbiter bus: per-channel producer results in, one registered
// writeback bundle out. Channel c occupies bits [c*W +: W] of every in_* bus.
interface lc4_wb_arbiter_if #(
   parameter int NCH   = 2,
   parameter int ROB_W = 2,
   parameter int PRD_W = 4
);
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic [NCH*ROB_W-1:0] in_rob_index;
   logic [NCH*PRD_W-1:0] in_prd;
   logic [NCH-1:0]       in_regfile_we;
   logic [NCH-1:0]       in_nzp_we;
   logic [NCH*16-1:0]    in_rddata;
   logic [NCH*16-1:0]    in_pc_redirect;

   logic                 W_valid;
   logic [2:0]           W_channel;
   logic [ROB_W-1:0]     W_rob_index;
   logic [PRD_W-1:0]     W_prd;
   logic [15:0]          W_rddata;
   logic [15:0]          W_pc_redirect;
   logic [2:0]           W_nzp;
   logic                 W_regfile_we;
   logic                 W_nzp_we;

   modport master (
      output in_valid, in_rob_index, in_prd, in_regfile_we, in_nzp_we,
             in_rddata, in_pc_redirect,
      input  in_ready, W_valid, W_channel, W_rob_index, W_prd, W_rddata,
             W_pc_redirect, W_nzp, W_regfile_we, W_nzp_we
   );

   modport slave (
      input  in_valid, in_rob_index, in_prd, in_regfile_we, in_nzp_we,
             in_rddata, in_pc_redirect,
      output in_ready, W_valid, W_channel, W_rob_index, W_prd, W_rddata,
             W_pc_redirect, W_nzp, W_regfile_we, W_nzp_we
   );
endinterface

// File: rtl/lc4_wb_arbiter.sv
// N-channel LC4 writeback stage: per-channel FIFOs drained one result per
// cycle by a round-robin arbiter into a registered writeback bundle.
module lc4_wb_arbiter #(
   parameter int NCH   = 2,
   parameter int DEPTH = 2,
   parameter int ROB_W = 2,
   parameter int PRD_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gwe,
   input  logic             flush,
   lc4_wb_arbiter_if.slave  wb
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [ROB_W-1:0] rob_index;
      logic [PRD_W-1:0] prd;
      logic             regfile_we;
      logic             nzp_we;
      logic [15:0]      rddata;
      logic [15:0]      pc_redirect;
   } entry_t;

   entry_t        mem_q    [NCH][DEPTH];
   entry_t        mem_d    [NCH][DEPTH];
   logic [PW-1:0] wr_ptr_q [NCH];
   logic [PW-1:0] wr_ptr_d [NCH];
   logic [PW-1:0] rd_ptr_q [NCH];
   logic [PW-1:0] rd_ptr_d [NCH];
   logic [CW-1:0] cnt_q    [NCH];
   logic [CW-1:0] cnt_d    [NCH];
   logic [RW-1:0] rr_ptr_q, rr_ptr_d;
   logic          w_valid_q, w_valid_d;
   logic [RW-1:0] w_ch_q, w_ch_d;
   entry_t        w_ent_q, w_ent_d;

   logic [NCH-1:0] req, push, pop;
   logic           grant_any;
   logic [RW-1:0]  grant;

   // Round-robin search starting at rr_ptr, wrapping past the top channel.
   always_comb begin
      grant_any = 1'b0;
      grant     = '0;
      for (int unsigned c = 0; c < NCH; c++) req[c] = (cnt_q[c] != '0);
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!grant_any && req[RW'((32'(rr_ptr_q) + i) % NCH)]) begin
            grant_any = 1'b1;
            grant     = RW'((32'(rr_ptr_q) + i) % NCH);
         end
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      rr_ptr_d  = rr_ptr_q;
      w_valid_d = w_valid_q;
      w_ch_d    = w_ch_q;
      w_ent_d   = w_ent_q;
      push      = '0;
      pop       = '0;
      if (gwe) begin
         if (flush) begin
            for (int unsigned c = 0; c < NCH; c++) begin
               wr_ptr_d[c] = '0;
               rd_ptr_d[c] = '0;
               cnt_d[c]    = '0;
            end
            w_valid_d = 1'b0;
         end else begin
            w_valid_d = grant_any;
            if (grant_any) begin
               pop[grant] = 1'b1;
               w_ch_d     = grant;
               w_ent_d    = mem_q[grant][rd_ptr_q[grant]];
               rr_ptr_d   = RW'((32'(grant) + 1) % NCH);
            end
            // Readiness comes from the pre-edge count, so a full FIFO never
            // accepts even when it is popped on the same edge.
            for (int unsigned c = 0; c < NCH; c++) begin
               push[c] = wb.in_valid[c] && (cnt_q[c] != FULL);
               if (push[c]) begin
                  mem_d[c][wr_ptr_q[c]] = '{
                     rob_index:   wb.in_rob_index[c*ROB_W +: ROB_W],
                     prd:         wb.in_prd[c*PRD_W +: PRD_W],
                     regfile_we:  wb.in_regfile_we[c],
                     nzp_we:      wb.in_nzp_we[c],
                     rddata:      wb.in_rddata[c*16 +: 16],
                     pc_redirect: wb.in_pc_redirect[c*16 +: 16]
                  };
                  wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
               end
               if (pop[c]) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
               cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         rr_ptr_q  <= '0;
         w_valid_q <= 1'b0;
         w_ch_q    <= '0;
         w_ent_q   <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         w_valid_q <= w_valid_d;
         w_ch_q    <= w_ch_d;
         w_ent_q   <= w_ent_d;
      end
   end

   // Storage is qualified by the counts, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
      wb.in_ready = '0;
      for (int unsigned c = 0; c < NCH; c++) wb.in_ready[c] = (cnt_q[c] != FULL);
      wb.W_valid       = w_valid_q;
      wb.W_channel     = 3'(w_ch_q);
      wb.W_rob_index   = w_ent_q.rob_index;
      wb.W_prd         = w_ent_q.prd;
      wb.W_rddata      = w_ent_q.rddata;
      wb.W_pc_redirect = w_ent_q.pc_redirect;
      if (w_ent_q.rddata[15])          wb.W_nzp = 3'b100;
      else if (w_ent_q.rddata == '0)   wb.W_nzp = 3'b010;
      else                             wb.W_nzp = 3'b001;
      wb.W_regfile_we  = w_ent_q.regfile_we & w_valid_q;
      wb.W_nzp_we      = w_ent_q.nzp_we & w_valid_q;
   end
endmodule
